mem_port_ctrl: RTL

- Single-ported, multi-cycle data memory controller that replaces the zero-latency dummy memory behind the MR and MW stages.
- Services MR-stage reads (mre, mr_addr) and MW-stage writes (mwe, mw_addr, mw_aluval).
- Returns mem_val with read_finished / write_finished completion pulses after configurable latencies.
- Arbitrates between simultaneous read and write requests, so the pipeline sees realistic stalls.

---
 rtl/mem_port_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-ported multi-cycle data memory controller.
// Serves MR-stage reads and MW-stage writes with configurable latency.
// A write beats a simultaneous read. Each access ends with a one-cycle DONE state,
// and the finished pulse is raised during that DONE cycle.
module mem_port_ctrl #(
  parameter int AW     = 8,
  parameter int RD_LAT = 3,
  parameter int WR_LAT = 2
) (
  input  logic        clk,
  input  logic        r,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] r_addr,
  input  logic [31:0] w_addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        r_finished,
  output logic        w_finished,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);
  localparam int         DEPTH  = 1 << AW;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   d_out_q;
  logic          r_fin_q;
  logic          w_fin_q;

  // Access operands captured at acceptance; data path, never reset
  logic [AW-1:0] idx_q;
  logic          oor_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem_q [0:DEPTH-1];

  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx;
  logic          r_oor;
  logic          w_oor;
  logic          wr_commit;
  logic          unused_addr_lsbs;

  // Word index ignores the byte offset; any set bit above the array means out of range
  assign r_idx = r_addr[AW+1:2];
  assign w_idx = w_addr[AW+1:2];
  assign r_oor = |r_addr[31:AW+2];
  assign w_oor = |w_addr[31:AW+2];
  assign unused_addr_lsbs = ^{r_addr[1:0], w_addr[1:0]};

  // Storage is written only at the completion edge, so a reset before then drops the write
  assign wr_commit = !r && (state_q == WRITE) && (cnt_q == 4'd0) && !oor_q;

  // Control FSM: arbitration, latency count, completion pulses and read data
  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      d_out_q <= 32'h0;
      r_fin_q <= 1'b0;
      w_fin_q <= 1'b0;
    end else begin
      r_fin_q <= 1'b0;
      w_fin_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (we) begin
            state_q <= WRITE;
            cnt_q   <= WR_CNT;
          end else if (re) begin
            state_q <= READ;
            cnt_q   <= RD_CNT;
          end
        end
        READ: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            r_fin_q <= 1'b1;
            d_out_q <= oor_q ? 32'h0 : mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WRITE: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            w_fin_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // Hold-off cycle: requests still asserted here must not start a second access
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture request operands when an access is accepted in IDLE
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (we) begin
        idx_q   <= w_idx;
        oor_q   <= w_oor;
        wdata_q <= d_in;
      end else if (re) begin
        idx_q   <= r_idx;
        oor_q   <= r_oor;
      end
    end
  end

  // Storage array; not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign d_out      = d_out_q;
  assign r_finished = r_fin_q;
  assign w_finished = w_fin_q;
  assign busy       = (state_q == READ) || (state_q == WRITE);

endmodule
